// File: rtl/collision_mover.sv
// collision_mover: single-step player movement controller in front of the
// collision RAM. A request computes a candidate position, bounds-checks it,
// then reads the collision map at the sprite's leading-edge points. The new
// position is committed only when every point reads zero.
//
// Optional build macro: COLLISION_MIDPOINT_EN adds a third check point at
// the midpoint of the leading edge (order: corner0, mid, corner1).
//
// Handshake: a request is accepted on a posedge where move_valid and
// move_ready are both high; move_ready is high only in IDLE, and requests
// seen while busy are dropped, never queued.
//
// Debug: state_dbg exposes the FSM state encoding for checkers.
module collision_mover #(
  parameter int MAP_W   = 320,
  parameter int MAP_H   = 240,
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int STEP    = 1,
  parameter int START_X = 152,
  parameter int START_Y = 112
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic [18:0] coll_addr,
  input  logic [3:0]  coll_data,
  output logic [8:0]  pos_x,
  output logic [7:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic        blocked,
  output logic [2:0]  state_dbg
);

`ifdef COLLISION_MIDPOINT_EN
  localparam int NPTS = 3;
`else
  localparam int NPTS = 2;
`endif
  localparam logic [1:0] LAST_IDX = 2'(NPTS - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_RD     = 3'd2,
    S_WT     = 3'd3,
    S_CHK    = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  dir_q;
  logic [1:0]  idx;
  logic        hit;
  logic [8:0]  cx;
  logic [7:0]  cy;

  // candidate position and bounds verdict for the latched direction
  logic [10:0] ext_x;
  logic [10:0] ext_y;
  logic [8:0]  cand_x;
  logic [7:0]  cand_y;
  logic        oob;

  // current check point and its collision address
  logic [8:0]  off_w;
  logic [7:0]  off_h;
  logic [8:0]  pt_x;
  logic [7:0]  pt_y;
  logic [18:0] pt_addr;

  assign move_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  // candidate position one STEP away and out-of-map detection (widened to avoid wrap)
  always_comb begin
    ext_x  = {2'b00, pos_x};
    ext_y  = {3'b000, pos_y};
    cand_x = pos_x;
    cand_y = pos_y;
    oob    = 1'b0;
    case (dir_q)
      DIR_UP: begin
        cand_y = pos_y - 8'(STEP);
        oob    = ext_y < 11'(STEP);
      end
      DIR_DOWN: begin
        cand_y = pos_y + 8'(STEP);
        oob    = (ext_y + 11'(STEP) + 11'(SPR_H)) > 11'(MAP_H);
      end
      DIR_LEFT: begin
        cand_x = pos_x - 9'(STEP);
        oob    = ext_x < 11'(STEP);
      end
      default: begin
        cand_x = pos_x + 9'(STEP);
        oob    = (ext_x + 11'(STEP) + 11'(SPR_W)) > 11'(MAP_W);
      end
    endcase
  end

  // leading-edge point idx at the candidate position, flattened to y*MAP_W + x
  always_comb begin
    off_w = (idx == 2'd0) ? 9'd0 : (idx == LAST_IDX) ? 9'(SPR_W - 1) : 9'(SPR_W / 2);
    off_h = (idx == 2'd0) ? 8'd0 : (idx == LAST_IDX) ? 8'(SPR_H - 1) : 8'(SPR_H / 2);
    pt_x  = cx;
    pt_y  = cy;
    case (dir_q)
      DIR_UP: begin
        pt_x = cx + off_w;
        pt_y = cy;
      end
      DIR_DOWN: begin
        pt_x = cx + off_w;
        pt_y = cy + 8'(SPR_H - 1);
      end
      DIR_LEFT: begin
        pt_x = cx;
        pt_y = cy + off_h;
      end
      default: begin
        pt_x = cx + 9'(SPR_W - 1);
        pt_y = cy + off_h;
      end
    endcase
    pt_addr = (19'(pt_y) * 19'(MAP_W)) + 19'(pt_x);
  end

  // move FSM: accept, bounds check, point reads with early exit, commit
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      pos_x     <= 9'(START_X);
      pos_y     <= 8'(START_Y);
      coll_addr <= '0;
      done      <= 1'b0;
      blocked   <= 1'b0;
      hit       <= 1'b0;
      idx       <= '0;
      dir_q     <= '0;
      cx        <= '0;
      cy        <= '0;
    end else begin
      done    <= 1'b0;
      blocked <= 1'b0;
      case (state)
        S_IDLE: begin
          if (move_valid) begin
            dir_q <= move_dir;
            hit   <= 1'b0;
            idx   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          cx <= cand_x;
          cy <= cand_y;
          if (oob) begin
            hit   <= 1'b1;
            state <= S_COMMIT;
          end else begin
            state <= S_RD;
          end
        end
        S_RD: begin
          coll_addr <= pt_addr;
          state     <= S_WT;
        end
        S_WT: begin
          state <= S_CHK;
        end
        S_CHK: begin
          if (coll_data != 4'd0) begin
            hit   <= 1'b1;
            state <= S_COMMIT;
          end else if (idx == LAST_IDX) begin
            state <= S_COMMIT;
          end else begin
            idx   <= idx + 2'd1;
            state <= S_RD;
          end
        end
        S_COMMIT: begin
          if (!hit) begin
            pos_x <= cx;
            pos_y <= cy;
            done  <= 1'b1;
          end else begin
            blocked <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
